key_event_sched: RTL



---
 rtl/key_pkg.sv | 18 +
 rtl/key_event_fsm.sv | 128 ++++++++++++
 rtl/key_event_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types for the key event scheduler.
// Event codes match the evt_type port encoding.
package key_pkg;

  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    LONG    = 2'd2,
    REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_event_fsm.sv
// One key: edge detect, press/long/repeat FSM and a one-deep event slot.
// KEY_EVT_REPEAT_EN builds in the auto-repeat counter for HELD.
module key_event_fsm
  import key_pkg::*;
#(
  parameter int LONG_CYC   = 1000,
`ifdef KEY_EVT_REPEAT_EN
  parameter int REPEAT_CYC = 200,
`endif
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_lvl,
  input  logic       grant,
  output logic       slot_valid,
  output logic [1:0] slot_type,
  output logic       drop
);

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYC - 1);
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'(REPEAT_CYC - 1);
`endif

  key_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             key_prev;
  logic             rise, fall;
  logic             emit;
  evt_type_e        etype;
  logic             slot_valid_n;
  evt_type_e        slot_t, slot_t_n;

  assign rise      = key_lvl & ~key_prev;
  assign fall      = ~key_lvl & key_prev;
  assign slot_type = slot_t;

  // State, counter, previous level and slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      key_prev   <= 1'b0;
      slot_valid <= 1'b0;
      slot_t     <= PRESS;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      key_prev   <= key_lvl;
      slot_valid <= slot_valid_n;
      slot_t     <= slot_t_n;
    end
  end

  // Next state and event generation; a release beats a threshold hit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    emit    = 1'b0;
    etype   = PRESS;
    unique case (state)
      IDLE: begin
        if (rise) begin
          emit    = 1'b1;
          etype   = PRESS;
          state_n = PRESSED;
          cnt_n   = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          emit    = 1'b1;
          etype   = RELEASE;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LONG_LAST) begin
          emit    = 1'b1;
          etype   = LONG;
          state_n = HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (fall) begin
          emit    = 1'b1;
          etype   = RELEASE;
          state_n = IDLE;
          cnt_n   = '0;
`ifdef KEY_EVT_REPEAT_EN
        end else if (cnt == REP_LAST) begin
          emit  = 1'b1;
          etype = REPEAT;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Slot accepts a new event when empty or being drained this cycle.
  always_comb begin
    slot_valid_n = slot_valid;
    slot_t_n     = slot_t;
    drop         = 1'b0;
    if (emit) begin
      if (!slot_valid || grant) begin
        slot_valid_n = 1'b1;
        slot_t_n     = etype;
      end else begin
        drop = 1'b1;
      end
    end else if (grant) begin
      slot_valid_n = 1'b0;
    end
  end

endmodule

// File: rtl/key_event_sched.sv
// Merges per-key events through a round-robin arbiter to one port.
// KEY_EVT_REPEAT_EN enables auto-repeat events while a key is held.
module key_event_sched
  import key_pkg::*;
#(
  parameter int KEY_NUM    = 4,
  parameter int LONG_CYC   = 1000,
  parameter int REPEAT_CYC = 200,
  parameter int CNT_W      = 16,
  localparam int KW = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_lvl,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [KW-1:0]      evt_key,
  output logic [1:0]         evt_type,
  output logic               ovf
);

  if (KEY_NUM < 1 || KEY_NUM > 16 || LONG_CYC < 2 ||
      REPEAT_CYC < 2) begin : g_bad_param
    $error("key_event_sched: parameter out of range");
  end

  logic [KEY_NUM-1:0]      slot_v;
  logic [KEY_NUM-1:0][1:0] slot_t;
  logic [KEY_NUM-1:0]      drop;
  logic [KEY_NUM-1:0]      grant;
  logic [KW-1:0]           ptr;
  logic [KW-1:0]           win;
  logic                    found;
  logic                    free;

  assign free = ~evt_valid | evt_ready;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_event_fsm #(
      .LONG_CYC   (LONG_CYC),
`ifdef KEY_EVT_REPEAT_EN
      .REPEAT_CYC (REPEAT_CYC),
`endif
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .key_lvl    (key_lvl[g]),
      .grant      (grant[g]),
      .slot_valid (slot_v[g]),
      .slot_type  (slot_t[g]),
      .drop       (drop[g])
    );
  end

  // Round-robin search upward from the pointer, wrapping at KEY_NUM.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int i = 0; i < KEY_NUM; i++) begin
      j = int'(ptr) + i;
      if (j >= KEY_NUM) j = j - KEY_NUM;
      if (!found && slot_v[j]) begin
        found = 1'b1;
        win   = KW'(j);
      end
    end
  end

  // Clear the winning slot in the cycle it moves to the output.
  always_comb begin
    grant = '0;
    if (free && found) grant[win] = 1'b1;
  end

  // Output register, rotating pointer and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= 2'd0;
      ptr       <= '0;
      ovf       <= 1'b0;
    end else begin
      ovf <= ovf | (|drop);
      if (free) begin
        if (found) begin
          evt_valid <= 1'b1;
          evt_key   <= win;
          evt_type  <= slot_t[win];
          ptr       <= (win == KW'(KEY_NUM - 1)) ?
                       '0 : win + KW'(1);
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule
